// File: rtl/gpio_irq_pkg.sv
// Shared FSM encoding and width helper for the GPIO interrupt arbiter.
// No logic; no flow control.
package gpio_irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2
  } arb_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// Rotating/fixed priority picker over the pending vector, wrapping at PIN_COUNT.
// Latency: combinational; backpressure: none, pure function of inputs.
module gpio_rr_pick #(
  parameter int PIN_COUNT = 32,
  parameter int ID_W      = 5
) (
  input  logic [PIN_COUNT-1:0] req,
  input  logic [ID_W-1:0]      start_ptr,
  input  logic                 rr_mode,
  output logic                 found,
  output logic [ID_W-1:0]      idx
);

  int start_i;
  int pos_i;

  // Walk offsets from the start point; the first hit is the highest priority.
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    pos_i   = 0;
    start_i = rr_mode ? int'(start_ptr) : 0;
    for (int k = 0; k < PIN_COUNT; k++) begin
      pos_i = start_i + k;
      if (pos_i >= PIN_COUNT) pos_i = pos_i - PIN_COUNT;
      if (!found && req[pos_i]) begin
        found = 1'b1;
        idx   = ID_W'(pos_i);
      end
    end
  end

endmodule

// File: rtl/gpio_irq_arbiter.sv
// Serializes GPIO pending bits into one vectored irq on a valid/ack handshake, then pulses int_clear.
// Latency: 1 cycle status->irq_valid, ack->clear next cycle; backpressure: irq_valid held until irq_ack.
module gpio_irq_arbiter
  import gpio_irq_pkg::*;
#(
  parameter int PIN_COUNT   = 32,
  parameter bit ROUND_ROBIN = 1'b1,
  localparam int ID_W       = clog2(PIN_COUNT),
  localparam int CNT_W      = clog2(PIN_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PIN_COUNT-1:0] int_status,
  input  logic                 arb_enable,
  output logic [PIN_COUNT-1:0] int_clear,
  output logic                 irq_valid,
  output logic [ID_W-1:0]      irq_id,
  input  logic                 irq_ack,
  output logic [CNT_W-1:0]     irq_count
);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 valid_q, valid_d;
  logic [PIN_COUNT-1:0] clear_q, clear_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;

  gpio_rr_pick #(
    .PIN_COUNT (PIN_COUNT),
    .ID_W      (ID_W)
  ) u_pick (
    .req       (int_status),
    .start_ptr (ptr_q),
    .rr_mode   (ROUND_ROBIN),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (arb_enable && pick_found) begin
          id_d    = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (irq_ack) state_d = CLEAR;
      end
      CLEAR: begin
        ptr_d   = (id_q == ID_W'(PIN_COUNT - 1)) ? '0 : id_q + ID_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so the registered copies line up with the state register.
  always_comb begin
    valid_d = (state_d == ISSUE);
    clear_d = '0;
    if (state_d == CLEAR) clear_d[id_d] = 1'b1;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < PIN_COUNT; i++) begin
      count_d = count_d + CNT_W'(int_status[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      clear_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      clear_q <= clear_d;
      count_q <= count_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign int_clear = clear_q;
  assign irq_count = count_q;

endmodule

// File: tb/tb_gpio_irq_arbiter.sv
// Bench: three arbiter instances (32-pin RR, 32-pin fixed, 5-pin RR) against a transaction-level model.
module tb_gpio_irq_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        arb_en;
  logic        ack;
  logic [31:0] pend  [3];
  logic [31:0] level [3];
  logic [31:0] pulse [3];

  logic [31:0] st0, st1, clr0, clr1;
  logic [4:0]  st2, clr2, id0, id1;
  logic [2:0]  id2, cnt2;
  logic [5:0]  cnt0, cnt1;
  logic        v0, v1, v2;

  assign st0 = pend[0];
  assign st1 = pend[1];
  assign st2 = pend[2][4:0];

  gpio_irq_arbiter #(.PIN_COUNT(32), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .int_status(st0), .arb_enable(arb_en), .int_clear(clr0),
    .irq_valid(v0), .irq_id(id0), .irq_ack(ack), .irq_count(cnt0));
  gpio_irq_arbiter #(.PIN_COUNT(32), .ROUND_ROBIN(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .int_status(st1), .arb_enable(arb_en), .int_clear(clr1),
    .irq_valid(v1), .irq_id(id1), .irq_ack(ack), .irq_count(cnt1));
  gpio_irq_arbiter #(.PIN_COUNT(5), .ROUND_ROBIN(1'b1)) u_p5 (
    .clk(clk), .rst_n(rst_n), .int_status(st2), .arb_enable(arb_en), .int_clear(clr2),
    .irq_valid(v2), .irq_id(id2), .irq_ack(ack), .irq_count(cnt2));

  int checks = 0;
  int errors = 0;

  // Transaction-level model: an outstanding request, a pending clear, last-grant pointer.
  int m_n  [3] = '{32, 32, 5};
  bit m_rr [3] = '{1'b1, 1'b0, 1'b1};
  bit m_busy [3];
  bit m_clr  [3];
  int m_id   [3];
  int m_ptr  [3];
  int m_cnt  [3];
  int g0 [$];
  int g1 [$];
  int g2 [$];

  function automatic logic [31:0] mask(input int i);
    return (m_n[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_n[i]) - 32'd1);
  endfunction

  function automatic int pick(input int i, input logic [31:0] s);
    int start;
    start = m_rr[i] ? m_ptr[i] : 0;
    for (int k = 0; k < m_n[i]; k++) begin
      if (s[(start + k) % m_n[i]]) return (start + k) % m_n[i];
    end
    return -1;
  endfunction

  function automatic logic [31:0] obs_clr(input int i);
    return (i == 0) ? clr0 : (i == 1) ? clr1 : {27'd0, clr2};
  endfunction
  function automatic logic [31:0] obs_id(input int i);
    return (i == 0) ? {27'd0, id0} : (i == 1) ? {27'd0, id1} : {29'd0, id2};
  endfunction
  function automatic logic [31:0] obs_cnt(input int i);
    return (i == 0) ? {26'd0, cnt0} : (i == 1) ? {26'd0, cnt1} : {29'd0, cnt2};
  endfunction
  function automatic logic [31:0] obs_valid(input int i);
    return (i == 0) ? {31'd0, v0} : (i == 1) ? {31'd0, v1} : {31'd0, v2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_busy[i] = 1'b0; m_clr[i] = 1'b0; m_id[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
  endtask

  task automatic model_edge(input int i);
    int p;
    if (!rst_n) begin
      model_reset(i);
    end else begin
      m_cnt[i] = $countones(pend[i]);
      if (m_clr[i]) begin
        m_clr[i] = 1'b0;
        m_ptr[i] = (m_id[i] + 1) % m_n[i];
      end else if (m_busy[i]) begin
        if (ack) begin m_busy[i] = 1'b0; m_clr[i] = 1'b1; end
      end else if (arb_en) begin
        p = pick(i, pend[i]);
        if (p >= 0) begin m_id[i] = p; m_busy[i] = 1'b1; end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), obs_valid(i), {31'd0, m_busy[i]});
      chk($sformatf("id%0d", i), obs_id(i), m_id[i]);
      chk($sformatf("clear%0d", i), obs_clr(i), m_clr[i] ? (32'd1 << m_id[i]) : 32'd0);
      chk($sformatf("count%0d", i), obs_cnt(i), m_cnt[i]);
    end
  endtask

  function automatic int first_set(input logic [31:0] v);
    for (int b = 0; b < 32; b++) if (v[b]) return b;
    return -1;
  endfunction

  // One clock: model steps on the edge's inputs; the controller clears bits pulsed this cycle.
  task automatic cycle();
    logic [31:0] clr_now [3];
    for (int i = 0; i < 3; i++) clr_now[i] = obs_clr(i);
    for (int i = 0; i < 3; i++) model_edge(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      pend[i]  = ((pend[i] & ~clr_now[i]) | level[i] | pulse[i]) & mask(i);
      pulse[i] = '0;
    end
    if (clr_now[0] != 0) g0.push_back(first_set(clr_now[0]));
    if (clr_now[1] != 0) g1.push_back(first_set(clr_now[1]));
    if (clr_now[2] != 0) g2.push_back(first_set(clr_now[2]));
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin pend[i] = '0; level[i] = '0; pulse[i] = '0; end
    cycle();
    cycle();
    rst_n = 1'b1;
    g0.delete(); g1.delete(); g2.delete();
  endtask

  initial begin
    int exp_rr [4];
    int exp_p5 [4];
    rst_n = 1'b0; arb_en = 1'b0; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin pend[i] = '0; level[i] = '0; pulse[i] = '0; model_reset(i); end
    #1;
    check_all();
    do_reset();

    // Single pin 4 with ack held high.
    arb_en = 1'b1; ack = 1'b1;
    for (int i = 0; i < 3; i++) pend[i] = 32'h10 & mask(i);
    cycle();
    chk("first_valid", {31'd0, v0}, 32'd1);
    chk("first_id", {27'd0, id0}, 32'd4);
    chk("first_count", {26'd0, cnt0}, 32'd1);
    cycle();
    chk("first_clear", clr0, 32'h10);
    for (int c = 0; c < 4; c++) cycle();
    chk("count_drained", {26'd0, cnt0}, 32'd0);

    // Level sources held: rotation in RR, always pin 0 in fixed, wrap on 5 pins.
    do_reset();
    arb_en = 1'b1; ack = 1'b1;
    level[0] = 32'h105; level[1] = 32'h105; level[2] = 32'h11;
    for (int i = 0; i < 3; i++) pend[i] = level[i];
    for (int c = 0; c < 13; c++) cycle();
    exp_rr = '{0, 2, 8, 0};
    exp_p5 = '{0, 4, 0, 4};
    chk("rr_grants", g0.size(), 32'd4);
    chk("fix_grants", g1.size(), 32'd4);
    chk("p5_grants", g2.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_order%0d", k), g0[k], exp_rr[k]);
      chk($sformatf("fix_order%0d", k), g1[k], 32'd0);
      chk($sformatf("p5_order%0d", k), g2[k], exp_p5[k]);
    end

    // Stalled ack: enable and status drop while the request is outstanding.
    do_reset();
    arb_en = 1'b1; ack = 1'b0;
    for (int i = 0; i < 3; i++) pend[i] = 32'h8;
    cycle();
    arb_en = 1'b0;
    for (int i = 0; i < 3; i++) pend[i] = '0;
    for (int c = 0; c < 10; c++) cycle();
    chk("stall_valid", {31'd0, v0}, 32'd1);
    chk("stall_id", {27'd0, id0}, 32'd3);
    ack = 1'b1;
    cycle();
    chk("stall_clear", clr0, 32'h8);
    chk("stall_valid_off", {31'd0, v0}, 32'd0);
    cycle();
    cycle();

    // Random traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ack    = ($urandom_range(0, 3) != 0);
      arb_en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 2) == 0) pulse[i] = 32'd1 << $urandom_range(0, m_n[i] - 1);
        if ($urandom_range(0, 40) == 0) level[i] = ($urandom & $urandom & $urandom) & mask(i);
        if ($urandom_range(0, 30) == 0) level[i] = '0;
      end
      cycle();
    end

    // Reset in the middle of a handshake; pointer must restart at 0.
    do_reset();
    arb_en = 1'b1; ack = 1'b0;
    level[0] = 32'h44; level[1] = 32'h44; level[2] = 32'h4;
    for (int i = 0; i < 3; i++) pend[i] = level[i];
    cycle();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_id", {27'd0, id0}, 32'd6);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);
    #1;
    check_all();
    cycle();
    cycle();
    rst_n = 1'b1;
    g0.delete(); g1.delete(); g2.delete();
    ack = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    chk("post_rst_grants", g0.size(), 32'd1);
    chk("post_rst_id", g0[0], 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
